// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_mult_seq_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Booth recoding of {Q[0], q(-1)}: the remaining codes are shift-only.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // The iteration counter must hold N+1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/booth_multi.sv
// Combinational radix-2 Booth step: optional add/subtract of M into A, then an
// arithmetic right shift across {A, Q}. Q carries q(-1) in bit 0.
module booth_multi
    import booth_mult_seq_pkg::*;
#(
    parameter int unsigned n = 9
) (
    input  logic [n-1:0] A_in,
    input  logic [n-1:0] M,
    input  logic [n:0]   Q_in,
    output logic [n-1:0] A_out,
    output logic [n:0]   Q_out
);

    logic [n-1:0] sum;
    logic [2*n:0] cat;

    // Select A+M, A-M or A according to the Booth pair.
    always_comb begin
        sum = A_in;
        case (Q_in[1:0])
            BOOTH_ADD: sum = A_in + M;
            BOOTH_SUB: sum = A_in - M;
            default:   sum = A_in;
        endcase
    end

    // Arithmetic shift right by one across the concatenated {A, Q}.
    always_comb begin
        cat   = {sum[n-1], sum, Q_in[n:1]};
        A_out = cat[2*n:n+1];
        Q_out = cat[n:0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: signed N x N -> signed 2N product.
// One step per clock through booth_multi; start/busy/done handshake.
module booth_mult_seq
    import booth_mult_seq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [N-1:0]   multiplicand,
    input  logic signed [N-1:0]   multiplier,
    output logic                  busy,
    output logic                  done,
    output logic signed [2*N-1:0] product
);

    // One extra bit keeps -2^(N-1) negatable on the subtract path.
    localparam int unsigned W  = N + 1;
    localparam int unsigned CW = cnt_width(N);

    state_e        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  m_q;
    logic [W:0]    q_q;
    logic [CW-1:0] count_q;

    logic [W-1:0]  a_next;
    logic [W:0]    q_next;

    booth_multi #(
        .n (W)
    ) u_step (
        .A_in  (a_q),
        .M     (m_q),
        .Q_in  (q_q),
        .A_out (a_next),
        .Q_out (q_next)
    );

    // Controller FSM with registered busy/done/product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= '0;
                        m_q     <= {multiplicand[N-1], multiplicand};
                        q_q     <= {multiplier[N-1], multiplier, 1'b0};
                        count_q <= CW'(N + 1);
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_next;
                    q_q     <= q_next;
                    count_q <= count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        // Low 2N bits of {A, Q without q(-1)}; the top two are sign copies.
                        product <= {a_next[N-2:0], q_next[W:1]};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
